// File: rtl/pipelined_addsub_rca_if.sv
// Operand/result bus for pipelined_addsub_rca.
// Groups the input handshake (in_valid/in_ready with A, B, Cin, Sub) and the
// output handshake (out_valid/out_ready with Sum, Cout, Ovf).
//   master : the side that supplies operands and consumes results
//   slave  : the arithmetic unit itself
interface pipelined_addsub_rca_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/pipelined_addsub_rca.sv
// Pipelined ripple-carry adder/subtractor.
// The WIDTH-bit carry chain is cut into STAGES equal segments with a register
// after each one, so one operation can be accepted every clock. Stage k holds
// the result with segments 0..k already summed plus the carry into segment
// k+1. The last stage register is the output.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (clears all stages, drops in-flight ops)
//   bus : slave side of pipelined_addsub_rca_if
//         in_valid/in_ready, A, B, Cin, Sub  -> operands
//         out_valid/out_ready, Sum, Cout, Ovf -> result
module pipelined_addsub_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_addsub_rca_if.slave  bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int MSB  = WIDTH - 1;
  localparam int LAST = STAGES - 1;

  generate
    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
      $error("pipelined_addsub_rca: STAGES must be in 1..WIDTH");
    end
    if (WIDTH % STAGES != 0) begin : g_bad_width
      $error("pipelined_addsub_rca: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  // Per-stage state. a/b keep the (already inverted for Sub) operands so later
  // segments and the overflow sign check can use them.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];

  // Whole pipe moves together; it only stops when a result is waiting and
  // downstream refuses it.
  logic adv;
  assign adv          = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready = adv;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_sum;
      logic             src_c;
      logic             src_v;
      logic [SEG:0]     seg_res;
      logic [WIDTH-1:0] merged;

      if (gi == 0) begin : g_first
        // Subtraction is A + ~B + 1: invert B at capture, force carry-in.
        assign src_a   = bus.A;
        assign src_b   = bus.Sub ? ~bus.B : bus.B;
        assign src_sum = '0;
        assign src_c   = bus.Sub | bus.Cin;
        assign src_v   = bus.in_valid;
      end else begin : g_next
        assign src_a   = a_q[gi-1];
        assign src_b   = b_q[gi-1];
        assign src_sum = sum_q[gi-1];
        assign src_c   = carry_q[gi-1];
        assign src_v   = valid_q[gi-1];
      end

      // Ripple segment gi; the extra top bit is the carry into the next segment.
      assign seg_res = {1'b0, src_a[gi*SEG +: SEG]}
                     + {1'b0, src_b[gi*SEG +: SEG]}
                     + {{SEG{1'b0}}, src_c};

      always_comb begin
        merged                = src_sum;
        merged[gi*SEG +: SEG] = seg_res[SEG-1:0];
      end

      assign sum_d[gi]   = merged;
      assign a_d[gi]     = src_a;
      assign b_d[gi]     = src_b;
      assign carry_d[gi] = seg_res[SEG];
      assign valid_d[gi] = src_v;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign bus.out_valid = valid_q[LAST];
  assign bus.Sum       = sum_q[LAST];
  assign bus.Cout      = carry_q[LAST];
  // Signed overflow: operands of equal sign giving a result of the other sign.
  assign bus.Ovf       = (a_q[LAST][MSB] == b_q[LAST][MSB]) &&
                         (sum_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_pipelined_addsub_rca.sv
module tb_pipelined_addsub_rca;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_addsub_rca_if #(.WIDTH(16)) b16 ();
  pipelined_addsub_rca_if #(.WIDTH(8))  b8a ();
  pipelined_addsub_rca_if #(.WIDTH(8))  b8b ();

  pipelined_addsub_rca #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  pipelined_addsub_rca #(.WIDTH(8),  .STAGES(1)) dut8a (.clk(clk), .rst(rst), .bus(b8a.slave));
  pipelined_addsub_rca #(.WIDTH(8),  .STAGES(8)) dut8b (.clk(clk), .rst(rst), .bus(b8b.slave));

  typedef struct packed {
    logic        v;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp_t        e;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   n_acc = 0;
  int   n_out = 0;
  exp_t pipe [4];   // reference: one slot per cycle of latency

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic from plain integer rules.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t   r;
    longint ua, ub, sa, sb, u, s;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (sub) begin
      u = ua - ub;
      s = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      u = ua + ub + longint'(cin);
      s = sa + sb + longint'(cin);
      r.cout = (u > 65535);
    end
    r.sum = 16'(u & 65535);
    r.ovf = (s > 32767) || (s < -32768);
    r.v   = 1'b1;
    return r;
  endfunction

  function automatic void clear_pipe();
    for (int k = 0; k < 4; k++) pipe[k] = '0;
  endfunction

  // One clock cycle on the 16-bit unit: drive, check outputs against the
  // reference pipe, advance the reference by the handshake rules.
  task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic cin, input logic sub, input logic ordy, input exp_t e);
    logic exp_ov, exp_ir;
    b16.in_valid  = v;
    b16.A         = a;
    b16.B         = b;
    b16.Cin       = cin;
    b16.Sub       = sub;
    b16.out_ready = ordy;
    #1;
    exp_ov = pipe[3].v;
    exp_ir = !exp_ov || ordy;
    chk("out_valid", 32'(b16.out_valid), 32'(exp_ov));
    chk("in_ready",  32'(b16.in_ready),  32'(exp_ir));
    if (exp_ov) begin
      chk("Sum",  32'(b16.Sum),  32'(pipe[3].sum));
      chk("Cout", 32'(b16.Cout), 32'(pipe[3].cout));
      chk("Ovf",  32'(b16.Ovf),  32'(pipe[3].ovf));
      if (ordy) n_out++;
    end
    if (exp_ir) begin
      for (int k = 3; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0]   = e;
      pipe[0].v = v;
      if (v) n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic rcyc(input logic v, input logic ordy);
    logic [15:0] a, b;
    logic        cin, sub;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
    cyc(v, a, b, cin, sub, ordy, model(a, b, cin, sub));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rcyc(1'b0, 1'b1);
  endtask

  // 8-bit configurations: 0xFF + 0x01 + Cin=1, measure latency.
  task automatic t8(input int which, input int exp_lat);
    int   lat;
    logic ov, co, of;
    logic [7:0] s;
    if (which == 0) begin
      b8a.in_valid = 1'b1; b8a.A = 8'hFF; b8a.B = 8'h01; b8a.Cin = 1'b1; b8a.Sub = 1'b0;
    end else begin
      b8b.in_valid = 1'b1; b8b.A = 8'hFF; b8b.B = 8'h01; b8b.Cin = 1'b1; b8b.Sub = 1'b0;
    end
    #1;
    chk(which == 0 ? "w8s1_in_ready" : "w8s8_in_ready",
        32'(which == 0 ? b8a.in_ready : b8b.in_ready), 32'd1);
    @(negedge clk);
    b8a.in_valid = 1'b0;
    b8b.in_valid = 1'b0;
    lat = 1;
    ov  = (which == 0) ? b8a.out_valid : b8b.out_valid;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
      ov = (which == 0) ? b8a.out_valid : b8b.out_valid;
    end
    s  = (which == 0) ? b8a.Sum  : b8b.Sum;
    co = (which == 0) ? b8a.Cout : b8b.Cout;
    of = (which == 0) ? b8a.Ovf  : b8b.Ovf;
    chk(which == 0 ? "w8s1_latency" : "w8s8_latency", 32'(lat), 32'(exp_lat));
    chk(which == 0 ? "w8s1_Sum"  : "w8s8_Sum",  32'(s),  32'h01);
    chk(which == 0 ? "w8s1_Cout" : "w8s8_Cout", 32'(co), 32'd1);
    chk(which == 0 ? "w8s1_Ovf"  : "w8s8_Ovf",  32'(of), 32'd0);
    @(negedge clk);
    chk(which == 0 ? "w8s1_single" : "w8s8_single",
        32'(which == 0 ? b8a.out_valid : b8b.out_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int   acc0, out0;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{1'b1, 16'h0000, 1'b1, 1'b0}};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{1'b1, 16'h8000, 1'b0, 1'b1}};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{1'b1, 16'hFFFE, 1'b0, 1'b0}};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{1'b1, 16'h7FFF, 1'b1, 1'b1}};
    tbl[4] = '{16'h00FF, 16'h0F00, 1'b1, 1'b0, '{1'b1, 16'h1000, 1'b0, 1'b0}};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, '{1'b1, 16'h0000, 1'b1, 1'b0}};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{1'b1, 16'h0000, 1'b1, 1'b1}};

    rst = 1'b1;
    b16.in_valid = 1'b0; b16.A = '0; b16.B = '0; b16.Cin = 1'b0; b16.Sub = 1'b0; b16.out_ready = 1'b1;
    b8a.in_valid = 1'b0; b8a.A = '0; b8a.B = '0; b8a.Cin = 1'b0; b8a.Sub = 1'b0; b8a.out_ready = 1'b1;
    b8b.in_valid = 1'b0; b8b.A = '0; b8b.B = '0; b8b.Cin = 1'b0; b8b.Sub = 1'b0; b8b.out_ready = 1'b1;
    clear_pipe();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(b16.out_valid), 32'd0);
    chk("rst_in_ready",  32'(b16.in_ready),  32'd1);
    chk("rst_Sum",       32'(b16.Sum),       32'd0);
    chk("rst_Cout",      32'(b16.Cout),      32'd0);
    chk("rst_Ovf",       32'(b16.Ovf),       32'd0);
    @(negedge clk);

    // Directed vectors, one at a time: result must appear exactly 4 cycles later.
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, tbl[i].e);
      idle(4);
      $display("[TB] vector %0d: A=%h B=%h Cin=%0b Sub=%0b -> expect Sum=%h Cout=%0b Ovf=%0b",
               i, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e.sum, tbl[i].e.cout, tbl[i].e.ovf);
    end

    // Back-to-back stream of 8 random operations.
    out0 = n_out;
    for (int i = 0; i < 8; i++) rcyc(1'b1, 1'b1);
    idle(5);
    chk("stream_results", 32'(n_out - out0), 32'd8);

    // Backpressure: fill the pipe with the sink stalled, keep it stalled 5 more
    // cycles while offering new operands, then release and drain.
    acc0 = n_acc;
    out0 = n_out;
    for (int i = 0; i < 4; i++) rcyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) rcyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) rcyc(1'b1, 1'b1);
    idle(5);
    chk("bp_accepted", 32'(n_acc - acc0), 32'd7);
    chk("bp_drained",  32'(n_out - out0), 32'(n_acc - acc0));

    // Reset with three operations in flight and one offered during reset.
    for (int i = 0; i < 3; i++) rcyc(1'b1, 1'b1);
    rst = 1'b1;
    b16.in_valid = 1'b1;
    b16.A = 16'h4444;
    @(negedge clk);
    rst = 1'b0;
    b16.in_valid = 1'b0;
    clear_pipe();
    #1;
    chk("midrst_out_valid", 32'(b16.out_valid), 32'd0);
    chk("midrst_Sum",       32'(b16.Sum),       32'd0);
    idle(6);
    cyc(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, '{1'b1, 16'h2345, 1'b0, 1'b0});
    idle(4);

    // Random traffic with random bubbles and backpressure.
    acc0 = n_acc;
    out0 = n_out;
    for (int i = 0; i < 300; i++) rcyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    idle(6);
    chk("rand_balance", 32'(n_out - out0), 32'(n_acc - acc0));
    $display("[TB] random phase: %0d accepted, %0d delivered", n_acc - acc0, n_out - out0);

    // Other configurations.
    t8(0, 1);
    t8(1, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
